// File: rtl/bg_line_fetcher_if.sv
// VRAM read port and line-buffer write port shared by the background fetcher
// (master) and the arbiter / line buffer side (slave).
interface bg_line_fetcher_if;
  logic [12:0] rd_address;
  logic        oe_vram;
  logic        mem_gnt;
  logic [7:0]  read_data;
  logic        wr_en;
  logic [7:0]  wr_addr;
  logic [1:0]  wr_data;

  modport master (
    output rd_address,
    output oe_vram,
    input  mem_gnt,
    input  read_data,
    output wr_en,
    output wr_addr,
    output wr_data
  );

  modport slave (
    input  rd_address,
    input  oe_vram,
    output mem_gnt,
    output read_data,
    input  wr_en,
    input  wr_addr,
    input  wr_data
  );
endinterface

// File: rtl/bg_line_fetcher.sv
// Background scanline fetcher: per tile reads the map byte and both bitplanes
// from VRAM, then streams palette-mapped shades into the line buffer.
module bg_line_fetcher #(
  parameter int LINE_PIXELS = 160,
  parameter int MAP_COLS    = 32
) (
  input  logic               clk_hdmi,
  input  logic               rst,
  input  logic               line_start,
  input  logic [7:0]         lcdc,
  input  logic [7:0]         scx,
  input  logic [7:0]         scy,
  input  logic [7:0]         ly,
  input  logic [7:0]         bgp,
  bg_line_fetcher_if.master  bus,
  output logic               busy,
  output logic               line_done
);

  typedef enum logic [3:0] {
    IDLE, MAP_RD, MAP_WT, LO_RD, LO_WT, HI_RD, HI_WT, PUSH, BLANK, DONE
  } state_t;

  localparam logic [7:0] LAST_PIX = 8'(LINE_PIXELS - 1);
  localparam logic [4:0] LAST_COL = 5'(MAP_COLS - 1);

  state_t      state_q, state_d;
  logic [7:0]  wr_addr_q, wr_addr_d;
  logic [4:0]  tile_count_q, tile_count_d;
  logic [4:0]  col_q, col_d;
  logic [2:0]  px_q, px_d;

  logic        map_sel_q, map_sel_d;
  logic        tdata_sel_q, tdata_sel_d;
  logic [2:0]  fine_x_q, fine_x_d;
  logic [7:0]  yy_q, yy_d;
  logic [7:0]  bgp_q, bgp_d;
  logic [7:0]  idx_q, idx_d;
  logic [7:0]  lo_q, lo_d;
  logic [7:0]  hi_q, hi_d;

  logic        accept;
  logic [12:0] map_addr;
  logic [12:0] tile_base;
  logic [12:0] tile_lo;
  logic [1:0]  color;
  logic        skip_px;
  logic        last_wr;
  logic        oe_vram;
  logic [12:0] rd_address;
  logic        wr_en;
  logic [1:0]  wr_data;
  logic        unused_lcdc;

  function automatic logic [1:0] pal_shade(input logic [7:0] pal, input logic [1:0] c);
    logic [1:0] s;
    case (c)
      2'd0:    s = pal[1:0];
      2'd1:    s = pal[3:2];
      2'd2:    s = pal[5:4];
      default: s = pal[7:6];
    endcase
    return s;
  endfunction

  assign busy        = (state_q != IDLE) && (state_q != DONE);
  assign accept      = line_start && !busy && lcdc[7];
  assign unused_lcdc = ^{lcdc[6:5], lcdc[2:1]};

  assign map_addr  = (map_sel_q ? 13'h1C00 : 13'h1800)
                   + {3'b000, yy_q[7:3], 5'b00000}
                   + {8'h00, col_q};
  // Unsigned mode indexes from 0x0000; signed mode centres on 0x1000.
  assign tile_base = tdata_sel_q ? {1'b0, idx_q, 4'h0}
                                 : 13'h1000 + {idx_q[7], idx_q, 4'h0};
  assign tile_lo   = tile_base + {9'h000, yy_q[2:0], 1'b0};

  // Pixels leave MSB first; leading fine-scroll pixels of the first tile are dropped.
  assign color   = {hi_q[~px_q], lo_q[~px_q]};
  assign skip_px = (tile_count_q == 5'd0) && (px_q < fine_x_q);

  always_comb begin
    state_d      = state_q;
    wr_addr_d    = wr_addr_q;
    tile_count_d = tile_count_q;
    col_d        = col_q;
    px_d         = px_q;
    map_sel_d    = map_sel_q;
    tdata_sel_d  = tdata_sel_q;
    fine_x_d     = fine_x_q;
    yy_d         = yy_q;
    bgp_d        = bgp_q;
    idx_d        = idx_q;
    lo_d         = lo_q;
    hi_d         = hi_q;
    oe_vram      = 1'b0;
    rd_address   = 13'h0000;
    wr_en        = 1'b0;
    wr_data      = 2'b00;
    line_done    = 1'b0;
    last_wr      = 1'b0;

    unique case (state_q)
      IDLE, DONE: begin
        line_done = (state_q == DONE);
        state_d   = IDLE;
        if (accept) begin
          map_sel_d    = lcdc[3];
          tdata_sel_d  = lcdc[4];
          fine_x_d     = scx[2:0];
          yy_d         = ly + scy;
          bgp_d        = bgp;
          wr_addr_d    = 8'h00;
          tile_count_d = 5'd0;
          col_d        = 5'(int'(scx[7:3]) % MAP_COLS);
          px_d         = 3'd0;
          state_d      = lcdc[0] ? MAP_RD : BLANK;
        end
      end
      MAP_RD: begin
        oe_vram    = 1'b1;
        rd_address = map_addr;
        if (bus.mem_gnt) state_d = MAP_WT;
      end
      MAP_WT: begin
        idx_d   = bus.read_data;
        state_d = LO_RD;
      end
      LO_RD: begin
        oe_vram    = 1'b1;
        rd_address = tile_lo;
        if (bus.mem_gnt) state_d = LO_WT;
      end
      LO_WT: begin
        lo_d    = bus.read_data;
        state_d = HI_RD;
      end
      HI_RD: begin
        oe_vram    = 1'b1;
        rd_address = tile_lo + 13'd1;
        if (bus.mem_gnt) state_d = HI_WT;
      end
      HI_WT: begin
        hi_d    = bus.read_data;
        px_d    = 3'd0;
        state_d = PUSH;
      end
      PUSH: begin
        px_d = px_q + 3'd1;
        if (!skip_px) begin
          wr_en     = 1'b1;
          wr_data   = pal_shade(bgp_q, color);
          wr_addr_d = wr_addr_q + 8'd1;
          last_wr   = (wr_addr_q == LAST_PIX);
        end
        // The final pixel ends the line even mid-tile; the tail is never written.
        if (last_wr) begin
          state_d = DONE;
        end else if (px_q == 3'd7) begin
          state_d      = MAP_RD;
          tile_count_d = tile_count_q + 5'd1;
          col_d        = (col_q == LAST_COL) ? 5'd0 : col_q + 5'd1;
        end
      end
      BLANK: begin
        wr_en     = 1'b1;
        wr_addr_d = wr_addr_q + 8'd1;
        if (wr_addr_q == LAST_PIX) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_hdmi or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      wr_addr_q    <= 8'h00;
      tile_count_q <= 5'd0;
      col_q        <= 5'd0;
      px_q         <= 3'd0;
    end else begin
      state_q      <= state_d;
      wr_addr_q    <= wr_addr_d;
      tile_count_q <= tile_count_d;
      col_q        <= col_d;
      px_q         <= px_d;
    end
  end

  // Line parameters and fetched bytes are only consumed under control state.
  always_ff @(posedge clk_hdmi) begin
    map_sel_q   <= map_sel_d;
    tdata_sel_q <= tdata_sel_d;
    fine_x_q    <= fine_x_d;
    yy_q        <= yy_d;
    bgp_q       <= bgp_d;
    idx_q       <= idx_d;
    lo_q        <= lo_d;
    hi_q        <= hi_d;
  end

  assign bus.oe_vram    = oe_vram;
  assign bus.rd_address = rd_address;
  assign bus.wr_en      = wr_en;
  assign bus.wr_addr    = wr_en ? wr_addr_q : 8'h00;
  assign bus.wr_data    = wr_data;

endmodule

// File: doc/bg_line_fetcher.md
BG_LINE_FETCHER -- requirements
Module: bg_line_fetcher

Interface
REQ-001 SHALL have parameter LINE_PIXELS, default 160: pixels written per scanline.
REQ-002 SHALL have parameter MAP_COLS, default 32: background map width in tiles; column index wraps modulo this value.
REQ-003 SHALL have ports:
- clk_hdmi  in  1  : the only clock.
- rst  in  1  : asynchronous reset, active-high.
- line_start  in  1  : one-cycle pulse requesting fetch of one scanline.
- lcdc  in  8  : LCD control; bit7 LCD on, bit4 tile data select, bit3 BG map select, bit0 BG enable.
- scx  in  8  : background X scroll.
- scy  in  8  : background Y scroll.
- ly  in  8  : scanline number.
- bgp  in  8  : background palette.
- rd_address  out  13  : VRAM byte address, relative to 0x8000.
- oe_vram  out  1  : VRAM read request.
- mem_gnt  in  1  : arbiter grant for the current request.
- read_data  in  8  : VRAM data, valid the cycle after a granted request.
- wr_en  out  1  : line-buffer write strobe.
- wr_addr  out  8  : line-buffer pixel index, 0..159.
- wr_data  out  2  : palette-mapped shade.
- busy  out  1  : high while a line is in progress.
- line_done  out  1  : one-cycle pulse after the last pixel write.

Function
REQ-004 Sampling: SHALL latch lcdc, scx, scy, ly and bgp on an accepted line_start; input changes mid-line SHALL have no effect on that line.
REQ-005 Acceptance conditions: SHALL accept line_start only when busy=0 and lcdc[7]=1. Otherwise SHALL ignore it, with no outputs changing.
REQ-006 States SHALL be IDLE, MAP_RD, MAP_WT, LO_RD, LO_WT, HI_RD, HI_WT, PUSH, BLANK, DONE.
REQ-007 Transitions:
- IDLE -> MAP_RD on an accepted start, or IDLE -> BLANK if latched lcdc[0]=0.
- Each *_RD state -> the matching *_WT state on the cycle mem_gnt=1.
- Each *_WT state -> the next *_RD state, or HI_WT -> PUSH.
- PUSH -> MAP_RD after its last pixel, or PUSH -> DONE when wr_addr reaches 159.
- BLANK -> DONE after 160 writes.
- DONE -> IDLE.
REQ-008 Request signalling: oe_vram SHALL be 1 exactly in MAP_RD, LO_RD and HI_RD; rd_address SHALL be held stable while oe_vram=1 and mem_gnt=0.
REQ-009 Data capture: read_data SHALL be captured in each *_WT state.
REQ-010 Row arithmetic: yy = (ly+scy) mod 256 (8-bit wrap); row = yy[7:3]; fine_y = yy[2:0].
REQ-011 Column arithmetic: col = (scx[7:3] + tile_count) mod MAP_COLS, where tile_count starts at 0 each line.
REQ-012 Map address = (lcdc[3] ? 0x1C00 : 0x1800) + row*32 + col.
REQ-013 Tile-data address: with lcdc[4]=1, tile_lo = idx*16 + fine_y*2 (idx unsigned). With lcdc[4]=0, tile_lo = 0x1000 + signed(idx)*16 + fine_y*2. The high byte address SHALL be tile_lo+1.
REQ-014 Pixel colour: for bit position b = 7..0, color = {hi[b], lo[b]} and wr_data = bgp[2*color+1 : 2*color].
REQ-015 PUSH rate and fine scroll: PUSH SHALL emit one pixel per cycle. For tile_count=0 only, the first scx[2:0] pixels SHALL be discarded, with no write and no wr_addr increment.
REQ-016 Write addressing: wr_addr SHALL start at 0 and increment by 1 after each write. Exactly 160 writes per line (21 tiles fetched when scx[2:0]≠0, otherwise 20). Pixels beyond index 159 SHALL be dropped.
REQ-017 BLANK: SHALL write wr_data=2'b00 for wr_addr 0..159, one per cycle, with no VRAM requests.
REQ-018 busy timing: busy SHALL go 1 the cycle after an accepted start and 0 in the cycle line_done=1.
REQ-019 Minimum latency (mem_gnt tied 1, scx[2:0]=0): 6 fetch cycles + 8 push cycles per tile, so 280 cycles from start to line_done.
REQ-020 Grant outside a request: mem_gnt=1 while oe_vram=0 SHALL have no effect.

Reset
REQ-021 Reset values: rst=1 SHALL asynchronously force state IDLE and all outputs to 0 (rd_address, oe_vram, wr_en, wr_addr, wr_data, busy, line_done), and clear tile_count.
REQ-022 Reset mid-line: SHALL abandon the line with no further writes. The first line_start after rst deasserts SHALL be accepted normally.

Verification
REQ-023 Basic line: lcdc=0x91, scx=0, scy=0, ly=0, bgp=0xE4, map byte 0x1800=0x01, tile 1 row0 lo=0xFF hi=0x00, mem_gnt=1 -> reads at 0x1800, 0x0010, 0x0011; wr_addr 0..7 written with wr_data=01; line_done at cycle 280.
REQ-024 Signed tile data: lcdc=0x81, map idx=0x80, ly=3 -> lo read at 0x0806, hi at 0x0807.
REQ-025 Fine scroll and map wrap: scx=0xFD -> first map read at col 31 (0x181F), second at col 0 (0x1800); 5 pixels discarded; exactly 160 writes; 21 map reads.
REQ-026 Backpressure: mem_gnt=0 for 5 cycles during LO_RD -> rd_address and oe_vram stable throughout; pixel data unchanged versus the no-stall run.
REQ-027 BG disabled and LCD off: lcdc=0x80 -> 160 writes of 00, oe_vram never 1. lcdc=0x00 -> line_start ignored, busy stays 0.
REQ-028 Mid-line reset: rst pulsed at cycle 50 -> all outputs 0 immediately; next line_start produces a complete 160-write line.
